// File: rtl/ysyx_23060203_scb.sv
// In-order GPR write scoreboard: tracks pending destination registers between
// dispatch and write-back, flags busy sources and out-of-order commits.
module ysyx_23060203_scb #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          issue_valid,
  input  logic [4:0]    issue_rd,
  output logic          issue_ready,
  input  logic          commit_valid,
  input  logic [4:0]    commit_rd,
  input  logic [4:0]    rs1,
  input  logic [4:0]    rs2,
  output logic          rs1_busy,
  output logic          rs2_busy,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          err
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ZERO_CNT = {(AW+1){1'b0}};

  logic [4:0]       rd_q  [DEPTH];
  logic [4:0]       rd_d  [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             empty_s, ready_s, push_s, cmt_s, pop_s;
  logic             rs1_hit_s, rs2_hit_s;

  assign empty_s = (cnt_q == ZERO_CNT);
  assign ready_s = (cnt_q != FULL_CNT);
  assign push_s  = issue_valid & ready_s & (issue_rd != 5'd0);
  assign cmt_s   = commit_valid & (commit_rd != 5'd0);
  assign pop_s   = cmt_s & ~empty_s;

  // Next-state for FIFO storage, pointers, occupancy and sticky error.
  always_comb begin
    rd_d   = rd_q;
    vld_d  = vld_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    // Pop clears before push sets; head == tail never coincides with both.
    if (pop_s) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + AW'(1);
    end else begin
      head_d = head_q;
    end
    if (push_s) begin
      rd_d[tail_q]  = issue_rd;
      vld_d[tail_q] = 1'b1;
      tail_d        = tail_q + AW'(1);
    end else begin
      tail_d = tail_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    if (cmt_s & empty_s) begin
      err_d = 1'b1;
    end else if (pop_s & (commit_rd != rd_q[head_q])) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i] <= 5'd0;
      end
      vld_q  <= {DEPTH{1'b0}};
      head_q <= {AW{1'b0}};
      tail_q <= {AW{1'b0}};
      cnt_q  <= ZERO_CNT;
      err_q  <= 1'b0;
    end else begin
      rd_q   <= rd_d;
      vld_q  <= vld_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  // Source hazard lookup across all valid entries; commits clear it next cycle.
  always_comb begin
    rs1_hit_s = 1'b0;
    rs2_hit_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rs1_hit_s = rs1_hit_s | (vld_q[i] & (rd_q[i] == rs1));
      rs2_hit_s = rs2_hit_s | (vld_q[i] & (rd_q[i] == rs2));
    end
  end

  assign rs1_busy    = rs1_hit_s & (rs1 != 5'd0);
  assign rs2_busy    = rs2_hit_s & (rs2 != 5'd0);
  assign issue_ready = ready_s;
  assign count       = cnt_q;
  assign empty       = empty_s;
  assign err         = err_q;

endmodule

// File: tb/tb_ysyx_23060203_scb.sv
// Directed and randomized bench for the GPR scoreboard against a queue model.
module tb_ysyx_23060203_scb;

  logic       clock = 1'b0;
  logic       reset;
  logic       issue_valid, commit_valid;
  logic [4:0] issue_rd, commit_rd, rs1, rs2;
  logic       issue_ready, rs1_busy, rs2_busy, empty, err;
  logic [2:0] count;

  int n_chk  = 0;
  int n_fail = 0;
  int q[$];
  bit m_err  = 1'b0;

  always #5 clock = ~clock;

  ysyx_23060203_scb #(.DEPTH(4), .AW(2)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .commit_valid(commit_valid), .commit_rd(commit_rd),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .count(count), .empty(empty), .err(err)
  );

  function automatic bit m_busy(logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (q[i]) if (q[i] == int'(r)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".ready"}, 32'(issue_ready), 32'(q.size() != 4));
    chk({tag, ".count"}, 32'(count), 32'(q.size()));
    chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, ".err"}, 32'(err), 32'(m_err));
    chk({tag, ".busy1"}, 32'(rs1_busy), 32'(m_busy(rs1)));
    chk({tag, ".busy2"}, 32'(rs2_busy), 32'(m_busy(rs2)));
  endtask

  // One cycle: drive at negedge, check before the edge, advance the model at the edge.
  task automatic cyc(string tag, bit iv, int ird, bit cv, int crd, int r1, int r2);
    bit ready, push, pop;
    issue_valid  = iv;
    issue_rd     = 5'(ird);
    commit_valid = cv;
    commit_rd    = 5'(crd);
    rs1          = 5'(r1);
    rs2          = 5'(r2);
    #1;
    check_all(tag);
    @(posedge clock);
    ready = (q.size() != 4);
    push  = iv && ready && (ird != 0);
    pop   = cv && (crd != 0) && (q.size() != 0);
    if (cv && crd != 0 && q.size() == 0) m_err = 1'b1;
    if (pop) begin
      if (q[0] != crd) m_err = 1'b1;
      void'(q.pop_front());
    end
    if (push) q.push_back(ird);
    @(negedge clock);
  endtask

  task automatic do_reset(string tag);
    reset = 1'b0;
    #1;
    q.delete();
    m_err = 1'b0;
    check_all(tag);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    issue_valid = 1'b0; issue_rd = 5'd0; commit_valid = 1'b0; commit_rd = 5'd0;
    rs1 = 5'd0; rs2 = 5'd0;
    #1;
    check_all("rst");
    @(negedge clock);
    reset = 1'b1;

    // basic
    cyc("b0", 1, 5, 0, 0, 0, 0);
    cyc("b1", 0, 0, 0, 0, 5, 0);
    cyc("b2", 0, 0, 1, 5, 5, 0);
    cyc("b3", 0, 0, 0, 0, 5, 0);

    // full
    for (int k = 1; k <= 4; k++) cyc("f_iss", 1, k, 0, 0, k, 0);
    cyc("f_full", 1, 5, 0, 0, 4, 5);
    cyc("f_both", 1, 5, 1, 1, 1, 5);
    cyc("f_after", 0, 0, 0, 0, 1, 5);
    for (int k = 2; k <= 4; k++) cyc("f_drain", 0, 0, 1, k, k, 0);

    // simultaneous
    cyc("s0", 1, 7, 0, 0, 0, 0);
    cyc("s1", 1, 8, 0, 0, 0, 0);
    cyc("s2", 1, 9, 1, 7, 8, 9);
    cyc("s3", 0, 0, 0, 0, 9, 7);
    cyc("s4", 0, 0, 1, 8, 8, 7);
    cyc("s5", 0, 0, 1, 9, 9, 8);

    // zero and duplicate
    cyc("z0", 1, 0, 0, 0, 0, 0);
    cyc("z1", 1, 6, 0, 0, 6, 0);
    cyc("z2", 1, 6, 0, 0, 6, 0);
    cyc("z3", 0, 0, 1, 6, 6, 0);
    cyc("z4", 0, 0, 1, 0, 6, 0);
    cyc("z5", 0, 0, 1, 6, 6, 0);
    cyc("z6", 0, 0, 0, 0, 6, 0);

    // errors
    cyc("e0", 0, 0, 1, 3, 3, 0);
    cyc("e1", 0, 0, 0, 0, 3, 0);
    do_reset("e_rst");
    cyc("e2", 1, 4, 0, 0, 4, 9);
    cyc("e3", 0, 0, 1, 9, 4, 9);
    cyc("e4", 0, 0, 0, 0, 4, 9);
    do_reset("e_rst2");

    // wrap and asynchronous reset
    for (int k = 1; k <= 10; k++) begin
      cyc("w_iss", 1, k, 0, 0, k, 0);
      cyc("w_cmt", 0, 0, 1, k, k, 0);
    end
    for (int k = 1; k <= 3; k++) cyc("w_fill", 1, k, 0, 0, 1, 2);
    cyc("w_pre", 0, 0, 0, 0, 1, 3);
    #2;
    reset = 1'b0;
    #1;
    q.delete();
    m_err = 1'b0;
    check_all("async");
    @(negedge clock);
    reset = 1'b1;
    cyc("post_rst", 1, 11, 0, 0, 11, 0);
    cyc("post_rst2", 0, 0, 0, 0, 11, 0);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      int crd;
      if (q.size() > 0 && $urandom_range(0, 9) != 0) crd = q[0];
      else crd = int'($urandom_range(0, 7));
      cyc("rnd", 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)), crd,
          int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      if ((n % 300) == 299 && m_err) do_reset("rnd_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
